// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder model: READ, RDSR1, RDID, WREN/WRDI and page program
// over single-bit SPI, driven from the system clock (one SCK edge per clock with cs_n low).
`timescale 1ns/1ps
module spi_flash_responder #(
  parameter int unsigned MEM_AW      = 8,
  parameter logic [23:0] JEDEC_ID    = 24'h012018,
  parameter int unsigned PROG_CYCLES = 64
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       si,
  output logic       so,
  output logic       so_oe,
  output logic [7:0] sr1,
  output logic       busy
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  // shift register is wide enough for an opcode or a full memory address
  localparam int unsigned SHW = (MEM_AW > 8) ? MEM_AW : 8;
  localparam int unsigned PW  = $clog2(PROG_CYCLES + 1);
  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(255);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_OPCODE   = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_DATA_OUT = 3'd3;
  localparam logic [2:0] S_DATA_IN  = 3'd4;
  localparam logic [2:0] S_IGNORE   = 3'd5;

  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  logic [2:0]        phase, phase_nx;
  logic [4:0]        cnt, cnt_nx;
  logic [SHW-2:0]    sh, sh_nx;
  logic [SHW-1:0]    sh_in;
  logic [MEM_AW-1:0] addr, addr_nx;
  logic [7:0]        out_sr, out_sr_nx;
  logic [1:0]        id_idx, id_idx_nx;
  logic [7:0]        op, op_nx;
  logic              pend, pend_nx;
  logic              pp_any, pp_any_nx;
  logic              wip, wip_nx;
  logic              wel, wel_nx;
  logic              armed, armed_nx;
  logic              so_nx, so_oe_nx;
  logic [PW-1:0]     pcnt, pcnt_nx;
  logic              load;
  logic [7:0]        load_byte;
  logic              mem_we;

  // array content at configuration time is erased flash (all ones); reset leaves it alone
  logic [7:0] mem [DEPTH] = '{default: 8'hFF};

  assign sh_in = {sh, si};
  assign sr1   = {6'b0, wel, wip};
  assign busy  = wip;

  // next-state and datapath decode for one SCK edge
  always_comb begin
    phase_nx  = phase;
    cnt_nx    = cnt;
    sh_nx     = sh;
    addr_nx   = addr;
    out_sr_nx = out_sr;
    id_idx_nx = id_idx;
    op_nx     = op;
    pend_nx   = pend;
    pp_any_nx = pp_any;
    wip_nx    = wip;
    wel_nx    = wel;
    armed_nx  = armed;
    pcnt_nx   = pcnt;
    so_nx     = so;
    so_oe_nx  = so_oe;
    load      = 1'b0;
    load_byte = 8'h00;
    mem_we    = 1'b0;

    // program timer runs regardless of chip select
    if (wip) begin
      if (pcnt == PW'(0)) begin
        wip_nx = 1'b0;
        wel_nx = 1'b0;
      end else begin
        pcnt_nx = pcnt - PW'(1);
      end
    end

    if (cs_n) begin
      phase_nx  = S_IDLE;
      cnt_nx    = 5'd0;
      so_nx     = 1'b0;
      so_oe_nx  = 1'b0;
      armed_nx  = 1'b1;
      pend_nx   = 1'b0;
      pp_any_nx = 1'b0;
      if (pend && (op == OP_WREN)) wel_nx = 1'b1;
      if (pend && (op == OP_WRDI)) wel_nx = 1'b0;
      if (pp_any) begin
        wip_nx  = 1'b1;
        pcnt_nx = PW'(PROG_CYCLES - 1);
      end
    end else begin
      sh_nx = sh_in[SHW-2:0];
      case (phase)
        S_IDLE: begin
          // a transaction only starts after cs_n was seen high since reset
          if (armed) begin
            phase_nx = S_OPCODE;
            cnt_nx   = 5'd1;
          end else begin
            phase_nx = S_IGNORE;
          end
        end
        S_OPCODE: begin
          cnt_nx = cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt_nx   = 5'd0;
            op_nx    = sh_in[7:0];
            phase_nx = S_IGNORE;
            case (sh_in[7:0])
              OP_RDSR1: begin
                phase_nx  = S_DATA_OUT;
                load      = 1'b1;
                load_byte = sr1;
              end
              OP_READ: if (!wip) phase_nx = S_ADDR;
              OP_PP:   if (!wip && wel) phase_nx = S_ADDR;
              OP_RDID: begin
                if (!wip) begin
                  phase_nx  = S_DATA_OUT;
                  load      = 1'b1;
                  load_byte = JEDEC_ID[23:16];
                  id_idx_nx = 2'd1;
                end
              end
              OP_WREN, OP_WRDI: if (!wip) pend_nx = 1'b1;
              default: ;
            endcase
          end
        end
        S_ADDR: begin
          cnt_nx = cnt + 5'd1;
          if (cnt == 5'd23) begin
            cnt_nx = 5'd0;
            if (op == OP_READ) begin
              phase_nx  = S_DATA_OUT;
              load      = 1'b1;
              load_byte = mem[sh_in[MEM_AW-1:0]];
              addr_nx   = sh_in[MEM_AW-1:0] + MEM_AW'(1);
            end else begin
              phase_nx = S_DATA_IN;
              addr_nx  = sh_in[MEM_AW-1:0];
            end
          end
        end
        S_DATA_IN: begin
          cnt_nx = cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt_nx    = 5'd0;
            mem_we    = 1'b1;
            pp_any_nx = 1'b1;
            // increment stays inside the 256-byte page
            addr_nx   = (addr & ~PAGE_MASK) | ((addr + MEM_AW'(1)) & PAGE_MASK);
          end
        end
        S_DATA_OUT: begin
          if (cnt == 5'd8) begin
            load = 1'b1;
            case (op)
              OP_READ: begin
                load_byte = mem[addr];
                addr_nx   = addr + MEM_AW'(1);
              end
              OP_RDSR1: load_byte = sr1;
              OP_RDID: begin
                case (id_idx)
                  2'd1:    load_byte = JEDEC_ID[15:8];
                  2'd2:    load_byte = JEDEC_ID[7:0];
                  default: load_byte = 8'h00;
                endcase
                if (id_idx != 2'd3) id_idx_nx = id_idx + 2'd1;
              end
              default: load_byte = 8'h00;
            endcase
          end else begin
            so_nx     = out_sr[7];
            out_sr_nx = {out_sr[6:0], 1'b0};
            cnt_nx    = cnt + 5'd1;
          end
        end
        S_IGNORE: pend_nx = 1'b0;
        default:  phase_nx = S_IGNORE;
      endcase

      // new output byte: bit 7 goes out on this same edge
      if (load) begin
        so_nx     = load_byte[7];
        out_sr_nx = {load_byte[6:0], 1'b0};
        so_oe_nx  = 1'b1;
        cnt_nx    = 5'd1;
      end
    end
  end

  // state register; reset wins over every simultaneous event
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      phase  <= S_IDLE;
      cnt    <= 5'd0;
      sh     <= '0;
      addr   <= '0;
      out_sr <= 8'h00;
      id_idx <= 2'd0;
      op     <= 8'h00;
      pend   <= 1'b0;
      pp_any <= 1'b0;
      wip    <= 1'b0;
      wel    <= 1'b0;
      armed  <= 1'b0;
      pcnt   <= '0;
      so     <= 1'b0;
      so_oe  <= 1'b0;
    end else begin
      phase  <= phase_nx;
      cnt    <= cnt_nx;
      sh     <= sh_nx;
      addr   <= addr_nx;
      out_sr <= out_sr_nx;
      id_idx <= id_idx_nx;
      op     <= op_nx;
      pend   <= pend_nx;
      pp_any <= pp_any_nx;
      wip    <= wip_nx;
      wel    <= wel_nx;
      armed  <= armed_nx;
      pcnt   <= pcnt_nx;
      so     <= so_nx;
      so_oe  <= so_oe_nx;
    end
  end

  // page program can only clear bits
  always_ff @(posedge clk_50MHz) begin
    if (!reset && mem_we) mem[addr] <= mem[addr] & sh_in[7:0];
  end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter MEM_AW, default 8: memory address width; memory holds 2^MEM_AW bytes.
REQ-002 Parameter JEDEC_ID, default 24'h012018: 3-byte ID returned by RDID, MSB byte first.
REQ-003 Parameter PROG_CYCLES, default 64: clk_50MHz cycles WIP stays set after a page program.
REQ-004 clk_50MHz  in  1  system clock; each rising edge with cs_n low is one SCK rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cs_n  in  1  chip select, active-low, from initiator.
REQ-007 si  in  1  serial data from initiator (dq[0]), MSB first.
REQ-008 so  out  1  serial data to initiator (dq[1]), MSB first.
REQ-009 so_oe  out  1  high only while so carries valid output bits.
REQ-010 sr1  out  8  status register 1: bit0 WIP, bit1 WEL, bits7:2 zero.
REQ-011 busy  out  1  equals sr1[0].

Function
REQ-012 Transaction starts at first edge with cs_n low after cs_n high; ends when cs_n is sampled high.
REQ-013 Bit counter shifts si in per active edge; first 8 bits = opcode; counter and phase clear on cs_n high.
REQ-014 Phases (state machine): IDLE -> OPCODE -> ADDR (24 bits, 0x03/0x02 only) -> DATA_OUT or DATA_IN; unsupported opcode -> IGNORE until cs_n high.
REQ-015 Output timing: so presents bit 7 of the first output byte on the edge sampling the last opcode/address bit; one new bit per following edge; so_oe high from that edge until cs_n high.
REQ-016 0x03 READ: after 24-bit address, stream mem[addr], addr+1, ...; address uses low MEM_AW bits, wraps from 2^MEM_AW-1 to 0.
REQ-017 0x05 RDSR1: stream sr1, re-sampled at each byte boundary, repeated until cs_n high.
REQ-018 0x9F RDID: stream 3 ID bytes, then 0x00 repeatedly.
REQ-019 0x06 WREN: sets WEL at cs_n high only if exactly 8 bits received; 0x04 WRDI likewise clears WEL.
REQ-020 0x02 PP: accepted only if WEL=1 and WIP=0, else IGNORE; after address, each complete data byte written as mem[a] <= mem[a] AND byte; a increments within the 256-byte page (low 8 bits wrap, upper bits fixed).
REQ-021 PP end: at cs_n high with >=1 complete data byte, WIP=1 for PROG_CYCLES cycles, then WIP=0 and WEL=0 same cycle; with zero data bytes, no WIP and WEL unchanged.
REQ-022 While WIP=1, only 0x05 is honoured; all other opcodes -> IGNORE, so_oe stays low.
REQ-023 cs_n high mid-byte: partial byte discarded; completed PP bytes remain written; WREN/WRDI with bit count != 8 has no effect.
REQ-024 cs_n low continuously across the WIP counter is allowed; counter runs independently of cs_n.
REQ-025 Memory is not cleared by reset; configuration-time content is 0xFF for every byte.

Reset
REQ-026 On reset: so=0, so_oe=0, sr1=0x00 (WIP and WEL cleared, program counter cleared), busy=0, phase=IDLE.
REQ-027 Reset during a transaction aborts it; responder stays in IGNORE until cs_n is sampled high, then IDLE.
REQ-028 Reset has priority over every simultaneous event, including WIP expiry and cs_n rising.

Verification
REQ-029 After reset, RDID 0x9F + 40 clocks -> so bytes 0x01, 0x20, 0x18, 0x00, 0x00; so_oe high from edge 8 until cs_n high.
REQ-030 WREN (8 bits), PP 0x02 addr 0x0000FE data 0xA5,0x3C,0x0F -> mem[0xFE]=0xA5, mem[0xFF]=0x3C, mem[0x00]=0x0F (page wrap); sr1=0x03 for 64 cycles, then 0x00.
REQ-031 RDSR1 held low across PP busy period -> bytes 0x03 ... then 0x00 after expiry; READ 0x03 during WIP -> so_oe stays 0.
REQ-032 READ addr 0x0000FF, 2 bytes, MEM_AW=8 -> 0x3C then 0x0F (wrap to 0); PP without WREN -> memory unchanged, sr1=0x00.
REQ-033 WREN with cs_n raised after 5 bits -> WEL=0; full WREN then WRDI -> sr1=0x00.
REQ-034 Reset asserted at bit 20 of READ address, released with cs_n still low -> so_oe=0 until cs_n high; next RDID returns 0x01 correctly.
